ifetch_prefetch_buffer: RTL and testbench

Instruction prefetch buffer between the instruction memory port and the CPU fetch stage. It issues sequential word fetches ahead of the core and holds returned instructions in an in-order FIFO. It presents {pc, instr} to the fetch/IF-ID boundary with a valid/ready handshake. A branch redirect flushes the buffer and discards responses still in flight.

---
 rtl/ifetch_prefetch_buffer.sv | 104 ++++++++++
 tb/tb_ifetch_prefetch_buffer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches ahead of the core and
// returns {pc, instr} in order; a redirect flushes the buffer and drops in-flight data.
module ifetch_prefetch_buffer #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_addr
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   fifo_pc    [DEPTH];
   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   pc_queue   [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, pq_rd_ptr, pq_wr_ptr;
   logic [CW-1:0] count, live, discard, outstanding;
   logic [CW+1:0] credit_used;
   logic          req_fire, resp_drop, resp_keep, pop;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^redirect_addr[1:0];

   // Every slot is reserved at issue time, so a kept response always finds FIFO room.
   assign outstanding    = live + discard;
   assign credit_used    = {2'b00, count} + {2'b00, live} + {2'b00, discard};
   assign imem_req_valid = !reset && !redirect && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc;

   assign req_fire  = imem_req_valid && imem_req_ready;
   assign resp_drop = imem_resp_valid && (discard != '0);
   assign resp_keep = imem_resp_valid && (discard == '0) && (live != '0);
   assign pop       = out_valid && out_ready;

   assign out_valid = (count != '0);
   assign out_pc    = out_valid ? fifo_pc[rd_ptr]    : 32'h0;
   assign out_instr = out_valid ? fifo_instr[rd_ptr] : 32'h0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc  <= RESET_PC;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         pq_rd_ptr <= '0;
         pq_wr_ptr <= '0;
         count     <= '0;
         live      <= '0;
         discard   <= '0;
      end else if (redirect) begin
         // A response arriving now retires the oldest outstanding request, whatever its class.
         fetch_pc  <= {redirect_addr[31:2], 2'b00};
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         pq_rd_ptr <= '0;
         pq_wr_ptr <= '0;
         count     <= '0;
         live      <= '0;
         discard   <= outstanding - CW'(imem_resp_valid && (outstanding != '0));
      end else begin
         if (req_fire) begin
            fetch_pc  <= fetch_pc + 32'd4;
            pq_wr_ptr <= pq_wr_ptr + 1'b1;
         end
         if (resp_keep) begin
            wr_ptr    <= wr_ptr + 1'b1;
            pq_rd_ptr <= pq_rd_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count   <= count + CW'(resp_keep) - CW'(pop);
         live    <= live + CW'(req_fire) - CW'(resp_keep);
         discard <= discard - CW'(resp_drop);
      end
   end

   always_ff @(posedge clk) begin
      if (req_fire)
         pc_queue[pq_wr_ptr] <= fetch_pc;
      if (resp_keep) begin
         fifo_pc[wr_ptr]    <= pc_queue[pq_rd_ptr];
         fifo_instr[wr_ptr] <= imem_resp_data;
      end
   end

`ifndef SYNTHESIS
   resp_has_owner: assert property (@(posedge clk) disable iff (reset)
      imem_resp_valid |-> (outstanding != '0));
`endif

endmodule

// File: tb/tb_ifetch_prefetch_buffer.sv
// Randomized bench for ifetch_prefetch_buffer against a queue-based reference model
// of the memory, the delivered instruction stream and the fetch address sequence.
module tb_ifetch_prefetch_buffer;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_addr;

   ifetch_prefetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk             (clk),
      .reset           (reset),
      .imem_req_valid  (imem_req_valid),
      .imem_req_addr   (imem_req_addr),
      .imem_req_ready  (imem_req_ready),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_pc          (out_pc),
      .out_instr       (out_instr),
      .out_ready       (out_ready),
      .redirect        (redirect),
      .redirect_addr   (redirect_addr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          epoch;
      int          due;
   } req_t;

   req_t        memq[$];   // accepted requests not yet answered, oldest first
   logic [31:0] bufq[$];   // PCs delivered to the buffer and not yet consumed
   logic [31:0] m_fetch_pc;
   int          epoch;
   int          cyc;
   int          n_checks;
   int          n_fail;
   int          pct_ready, pct_out_ready, pct_redirect, lat_min, lat_max;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): observed %h expected %h", tag, cyc, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset           = 1'b1;
      redirect        = 1'b0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      out_ready       = 1'b0;
      #1;
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'h0);
      check_eq("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
      check_eq("rst_req_addr", imem_req_addr, RESET_PC);
      check_eq("rst_out_pc", out_pc, 32'h0);
      check_eq("rst_out_instr", out_instr, 32'h0);
      memq.delete();
      bufq.delete();
      m_fetch_pc = RESET_PC;
      epoch++;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic step(input bit force_redir, input logic [31:0] faddr);
      bit          redir, rdy, ordy, hs, pop, exp_rv, exp_ov;
      logic [31:0] raddr;
      req_t        r;
      @(negedge clk);
      redir = force_redir || ($urandom_range(99) < pct_redirect);
      raddr = force_redir ? faddr : $urandom;
      rdy   = $urandom_range(99) < pct_ready;
      ordy  = $urandom_range(99) < pct_out_ready;
      redirect       = redir;
      redirect_addr  = raddr;
      imem_req_ready = rdy;
      out_ready      = ordy;
      if (memq.size() > 0 && memq[0].due <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = instr_of(memq[0].addr);
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = $urandom;
      end
      #1;
      exp_ov = (bufq.size() != 0);
      check_eq("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
      if (exp_ov) begin
         check_eq("out_pc", out_pc, bufq[0]);
         check_eq("out_instr", out_instr, instr_of(bufq[0]));
      end
      exp_rv = !redir && (bufq.size() + memq.size() < DEPTH);
      check_eq("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
      if (exp_rv)
         check_eq("req_addr", imem_req_addr, m_fetch_pc);
      hs  = exp_rv && rdy;
      pop = exp_ov && ordy && !redir;
      if (pop)
         void'(bufq.pop_front());
      if (imem_resp_valid) begin
         r = memq.pop_front();
         if (!redir && r.epoch == epoch)
            bufq.push_back(r.addr);
      end
      if (redir) begin
         epoch++;
         bufq.delete();
         m_fetch_pc = {raddr[31:2], 2'b00};
      end else if (hs) begin
         memq.push_back('{m_fetch_pc, epoch, cyc + $urandom_range(lat_max, lat_min)});
         m_fetch_pc = m_fetch_pc + 32'd4;
      end
      cyc++;
   endtask

   task automatic set_mode(input int rdy, input int ordy, input int redir, input int lmin, input int lmax);
      pct_ready     = rdy;
      pct_out_ready = ordy;
      pct_redirect  = redir;
      lat_min       = lmin;
      lat_max       = lmax;
   endtask

   initial begin
      bit reached;
      reset           = 1'b1;
      redirect        = 1'b0;
      redirect_addr   = 32'h0;
      imem_req_ready  = 1'b0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
      out_ready       = 1'b0;
      n_checks = 0;
      n_fail   = 0;
      epoch    = 0;
      cyc      = 0;
      m_fetch_pc = RESET_PC;

      // Streaming at latency 1 with the core always ready.
      set_mode(100, 100, 0, 1, 1);
      do_reset();
      repeat (12) step(1'b0, 32'h0);

      // Stalled core: fetch stops at DEPTH credits, then resumes.
      set_mode(100, 0, 0, 1, 1);
      do_reset();
      repeat (8) step(1'b0, 32'h0);
      set_mode(100, 100, 0, 1, 1);
      repeat (8) step(1'b0, 32'h0);

      // Redirect with responses in flight at latency 3.
      set_mode(100, 100, 0, 3, 3);
      do_reset();
      repeat (3) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0100);
      repeat (12) step(1'b0, 32'h0);

      // Redirect coinciding with a response and a pop, unaligned target.
      set_mode(100, 100, 0, 1, 1);
      repeat (6) step(1'b0, 32'h0);
      step(1'b1, 32'h0000_0203);
      repeat (8) step(1'b0, 32'h0);

      // Address wrap at the top of the address space.
      step(1'b1, 32'hFFFF_FFF8);
      repeat (10) step(1'b0, 32'h0);

      // Reset while entries are buffered and a request is in flight.
      set_mode(100, 0, 0, 3, 3);
      do_reset();
      reached = 1'b0;
      for (int i = 0; i < 20 && !reached; i++) begin
         step(1'b0, 32'h0);
         reached = (bufq.size() >= 3) && (memq.size() >= 1);
      end
      check_eq("reach_buffered_state", {31'b0, reached}, 32'h1);
      do_reset();
      set_mode(100, 100, 0, 1, 1);
      repeat (6) step(1'b0, 32'h0);

      // Randomized traffic.
      set_mode(70, 60, 5, 1, 4);
      repeat (3000) step(1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
